// File: rtl/tlul_pkg.sv
// ---------------------------------------------------------------------------
// tlul_pkg
// Shared definitions for the TL-UL master-side protocol monitor:
//   - A/D channel opcode encodings used by the monitor
//   - expected_d_opcode(): response opcode that a given request must receive
//   - legal_a_opcode(): request opcodes the monitor accepts
//   - bit indices of the sticky violation vector (err_vec)
// No ports (package).
// ---------------------------------------------------------------------------
package tlul_pkg;

    // A-channel request opcodes
    localparam logic [2:0] OP_PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] OP_GET              = 3'd4;

    // D-channel response opcodes
    localparam logic [2:0] OP_ACCESS_ACK       = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA  = 3'd1;

    // Largest legal a_size (log2 of bytes) on a 32-bit bus
    localparam logic [3:0] MAX_A_SIZE = 4'd2;

    // err_vec bit map
    localparam int ERR_W          = 7;
    localparam int ERR_A_UNSTABLE = 0;
    localparam int ERR_D_NOT_BUSY = 1;
    localparam int ERR_D_OPCODE   = 2;
    localparam int ERR_D_SIZE     = 3;
    localparam int ERR_A_BUSY     = 4;
    localparam int ERR_OVERFLOW   = 5;
    localparam int ERR_TIMEOUT    = 6;

    function automatic logic [2:0] expected_d_opcode(input logic [2:0] a_opcode);
        if (a_opcode == OP_GET) begin
            return OP_ACCESS_ACK_DATA;
        end
        return OP_ACCESS_ACK;
    endfunction

    function automatic logic legal_a_opcode(input logic [2:0] a_opcode);
        return (a_opcode == OP_PUT_FULL_DATA) ||
               (a_opcode == OP_PUT_PARTIAL_DATA) ||
               (a_opcode == OP_GET);
    endfunction

endpackage

// File: rtl/tlul_monitor_src_table.sv
// ---------------------------------------------------------------------------
// tlul_monitor_src_table
// Per-source-ID record of outstanding requests: {busy, opcode, size}.
// Ports:
//   master_clock_i / master_reset_i : clock, synchronous active-high reset
//   wr_en, wr_source, wr_opcode, wr_size : record a request (A fire)
//   clr_en, clr_source                    : retire a request (D fire)
//   rd_busy, rd_opcode, rd_size           : entry at clr_source before this edge
//   chk_busy                              : busy bit at wr_source before this edge
// A clear and a write to the same source on one edge leave the entry busy
// with the new request: the response retires the old one, the new one lands.
// ---------------------------------------------------------------------------
module tlul_monitor_src_table #(
    parameter int RS = 4
) (
    input  logic          master_clock_i,
    input  logic          master_reset_i,
    input  logic          wr_en,
    input  logic [RS-1:0] wr_source,
    input  logic [2:0]    wr_opcode,
    input  logic [3:0]    wr_size,
    input  logic          clr_en,
    input  logic [RS-1:0] clr_source,
    output logic          rd_busy,
    output logic [2:0]    rd_opcode,
    output logic [3:0]    rd_size,
    output logic          chk_busy
);

    localparam int DEPTH = 1 << RS;

    logic [DEPTH-1:0] busy_q;
    logic [2:0]       opcode_q [DEPTH];
    logic [3:0]       size_q   [DEPTH];

    assign rd_busy   = busy_q[clr_source];
    assign rd_opcode = opcode_q[clr_source];
    assign rd_size   = size_q[clr_source];
    assign chk_busy  = busy_q[wr_source];

    // Write is ordered after clear so a same-source handoff stays busy.
    always_ff @(posedge master_clock_i) begin
        if (master_reset_i) begin
            busy_q <= '0;
        end else begin
            if (clr_en) begin
                busy_q[clr_source] <= 1'b0;
            end
            if (wr_en) begin
                busy_q[wr_source] <= 1'b1;
            end
        end
    end

    // Payload is only meaningful while busy, so it needs no reset.
    always_ff @(posedge master_clock_i) begin
        if (wr_en && !master_reset_i) begin
            opcode_q[wr_source] <= wr_opcode;
            size_q[wr_source]   <= wr_size;
        end
    end

endmodule

// File: rtl/tlul_master_monitor.sv
// ---------------------------------------------------------------------------
// tlul_master_monitor
// Passive TL-UL protocol checker on the master side of a link. Tracks each
// outstanding request by source ID, checks responses against the request,
// checks A-channel hold stability, bounds outstanding count and response
// latency, and reports sticky violation flags.
// Ports:
//   master_clock_i, master_reset_i : clock, synchronous active-high reset
//   master_a_*                     : observed A channel (all inputs)
//   master_d_*                     : observed D channel (all inputs)
//   outstanding_o                  : live outstanding-transaction count
//   err_vec_o                      : sticky violation flags (see tlul_pkg)
//   err_o                          : OR of err_vec_o
// ---------------------------------------------------------------------------
module tlul_master_monitor
    import tlul_pkg::*;
#(
    parameter int          AW      = 32,
    parameter int          RS      = 4,
    parameter logic [RS:0] MAX     = (RS+1)'(2),
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic              master_clock_i,
    input  logic              master_reset_i,

    input  logic [2:0]        master_a_opcode,
    input  logic [2:0]        master_a_param,
    input  logic [3:0]        master_a_size,
    input  logic [RS-1:0]     master_a_source,
    input  logic [AW-1:0]     master_a_address,
    input  logic [3:0]        master_a_mask,
    input  logic [31:0]       master_a_data,
    input  logic              master_a_corrupt,
    input  logic              master_a_valid,
    input  logic              master_a_ready,

    input  logic [2:0]        master_d_opcode,
    input  logic [1:0]        master_d_param,
    input  logic [3:0]        master_d_size,
    input  logic [RS-1:0]     master_d_source,
    input  logic              master_d_denied,
    input  logic [31:0]       master_d_data,
    input  logic              master_d_corrupt,
    input  logic              master_d_valid,
    input  logic              master_d_ready,

    output logic [RS:0]       outstanding_o,
    output logic [ERR_W-1:0]  err_vec_o,
    output logic              err_o
);

    localparam int          AFW       = 3 + 3 + 4 + RS + AW + 4 + 32 + 1;
    localparam logic [RS:0] COUNT_SAT = '1;

    logic             a_fire;
    logic             d_fire;
    logic [AFW-1:0]   a_fields;
    logic [AFW-1:0]   a_fields_q;
    logic             a_stall_q;
    logic [RS:0]      count_q;
    logic [RS:0]      count_next;
    logic [15:0]      wd_q;
    logic [15:0]      wd_next;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_set;

    logic             tbl_rd_busy;
    logic [2:0]       tbl_rd_opcode;
    logic [3:0]       tbl_rd_size;
    logic             tbl_chk_busy;

    // D-channel payload fields carry no protocol rule this monitor checks.
    logic             unused_d_fields;
    assign unused_d_fields = ^{master_d_param, master_d_denied,
                               master_d_data, master_d_corrupt};

    assign a_fire = master_a_valid & master_a_ready;
    assign d_fire = master_d_valid & master_d_ready;

    assign a_fields = {master_a_opcode, master_a_param, master_a_size,
                       master_a_source, master_a_address, master_a_mask,
                       master_a_data, master_a_corrupt};

    tlul_monitor_src_table #(
        .RS (RS)
    ) u_src_table (
        .master_clock_i (master_clock_i),
        .master_reset_i (master_reset_i),
        .wr_en          (a_fire),
        .wr_source      (master_a_source),
        .wr_opcode      (master_a_opcode),
        .wr_size        (master_a_size),
        .clr_en         (d_fire),
        .clr_source     (master_d_source),
        .rd_busy        (tbl_rd_busy),
        .rd_opcode      (tbl_rd_opcode),
        .rd_size        (tbl_rd_size),
        .chk_busy       (tbl_chk_busy)
    );

    always_comb begin
        count_next = count_q;
        if (a_fire && !d_fire && count_q != COUNT_SAT) begin
            count_next = count_q + 1'b1;
        end else if (d_fire && !a_fire && count_q != '0) begin
            count_next = count_q - 1'b1;
        end
    end

    // Watchdog measures time since the last response while anything is
    // outstanding; the count used is the one before this edge.
    always_comb begin
        wd_next = wd_q;
        if (d_fire || count_q == '0) begin
            wd_next = '0;
        end else if (wd_q != TIMEOUT) begin
            wd_next = wd_q + 16'd1;
        end
    end

    always_comb begin
        err_set = '0;
        err_set[ERR_A_UNSTABLE] =
            (a_stall_q && (!master_a_valid || a_fields != a_fields_q)) ||
            (master_a_valid && (!legal_a_opcode(master_a_opcode) ||
                                master_a_size > MAX_A_SIZE));
        err_set[ERR_D_NOT_BUSY] = d_fire && !tbl_rd_busy;
        err_set[ERR_D_OPCODE]   = d_fire && tbl_rd_busy &&
                                  (master_d_opcode != expected_d_opcode(tbl_rd_opcode));
        err_set[ERR_D_SIZE]     = d_fire && tbl_rd_busy &&
                                  (master_d_size != tbl_rd_size);
        // A response retiring the same source on this edge makes it free.
        err_set[ERR_A_BUSY]     = a_fire && tbl_chk_busy &&
                                  !(d_fire && master_d_source == master_a_source);
        err_set[ERR_OVERFLOW]   = count_next > MAX;
        err_set[ERR_TIMEOUT]    = !d_fire && count_q != '0 && wd_next == TIMEOUT;
    end

    // Clearing a_stall_q on reset means no hold check spans a reset edge.
    always_ff @(posedge master_clock_i) begin
        if (master_reset_i) begin
            count_q   <= '0;
            wd_q      <= '0;
            err_q     <= '0;
            a_stall_q <= 1'b0;
        end else begin
            count_q   <= count_next;
            wd_q      <= wd_next;
            err_q     <= err_q | err_set;
            a_stall_q <= master_a_valid & ~master_a_ready;
        end
    end

    always_ff @(posedge master_clock_i) begin
        a_fields_q <= a_fields;
    end

    assign outstanding_o = count_q;
    assign err_vec_o     = err_q;
    assign err_o         = |err_q;

endmodule

// File: tb/tb_tlul_master_monitor.sv
module tb_tlul_master_monitor;

    localparam int AW = 32;
    localparam int RS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [2:0]    a_opcode = '0;
    logic [2:0]    a_param = '0;
    logic [3:0]    a_size = '0;
    logic [RS-1:0] a_source = '0;
    logic [AW-1:0] a_address = '0;
    logic [3:0]    a_mask = '0;
    logic [31:0]   a_data = '0;
    logic          a_corrupt = 1'b0;
    logic          a_valid = 1'b0;
    logic          a_ready = 1'b0;

    logic [2:0]    d_opcode = '0;
    logic [1:0]    d_param = '0;
    logic [3:0]    d_size = '0;
    logic [RS-1:0] d_source = '0;
    logic          d_denied = 1'b0;
    logic [31:0]   d_data = '0;
    logic          d_corrupt = 1'b0;
    logic          d_valid = 1'b0;
    logic          d_ready = 1'b0;

    logic [RS:0]   outstanding;
    logic [6:0]    err_vec;
    logic          err;

    int checks = 0;
    int failures = 0;

    string       tag_q[$];
    logic [RS:0] exp_out_q[$];
    logic [6:0]  exp_err_q[$];

    tlul_master_monitor #(
        .AW      (AW),
        .RS      (RS),
        .MAX     (5'd2),
        .TIMEOUT (16'd8)
    ) dut (
        .master_clock_i   (clk),
        .master_reset_i   (rst),
        .master_a_opcode  (a_opcode),
        .master_a_param   (a_param),
        .master_a_size    (a_size),
        .master_a_source  (a_source),
        .master_a_address (a_address),
        .master_a_mask    (a_mask),
        .master_a_data    (a_data),
        .master_a_corrupt (a_corrupt),
        .master_a_valid   (a_valid),
        .master_a_ready   (a_ready),
        .master_d_opcode  (d_opcode),
        .master_d_param   (d_param),
        .master_d_size    (d_size),
        .master_d_source  (d_source),
        .master_d_denied  (d_denied),
        .master_d_data    (d_data),
        .master_d_corrupt (d_corrupt),
        .master_d_valid   (d_valid),
        .master_d_ready   (d_ready),
        .outstanding_o    (outstanding),
        .err_vec_o        (err_vec),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL tb_time_limit: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    task automatic set_a(input logic v, input logic r, input logic [2:0] op,
                         input logic [RS-1:0] src, input logic [3:0] sz,
                         input logic [AW-1:0] addr);
        a_valid = v; a_ready = r; a_opcode = op; a_source = src;
        a_size = sz; a_address = addr; a_param = '0; a_mask = 4'hF;
        a_data = 32'hA5A5_0000 | addr; a_corrupt = 1'b0;
    endtask

    task automatic set_d(input logic v, input logic [2:0] op,
                         input logic [RS-1:0] src, input logic [3:0] sz);
        d_valid = v; d_ready = 1'b1; d_opcode = op; d_source = src; d_size = sz;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_ready = 1'b0;
        d_valid = 1'b0; d_ready = 1'b0;
    endtask

    // Push what the monitor must show after the next edge, then compare.
    task automatic step(input string tag, input logic [RS:0] eo, input logic [6:0] ee);
        string       t;
        logic [RS:0] o;
        logic [6:0]  e;
        tag_q.push_back(tag);
        exp_out_q.push_back(eo);
        exp_err_q.push_back(ee);
        @(posedge clk);
        #1;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            o = exp_out_q.pop_front();
            e = exp_err_q.pop_front();
            checks++;
            assert (outstanding === o) else begin
                failures++;
                $error("FAIL %s outstanding got=%0d exp=%0d", t, outstanding, o);
            end
            checks++;
            assert (err_vec === e) else begin
                failures++;
                $error("FAIL %s err_vec got=%b exp=%b", t, err_vec, e);
            end
            checks++;
            assert (err === (|e)) else begin
                failures++;
                $error("FAIL %s err_o got=%b exp=%b", t, err, |e);
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        idle();
        step(tag, 5'd0, 7'h00);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset("reset");
        step("idle_after_reset", 5'd0, 7'h00);

        // Get src 3 size 2, response two cycles later
        set_a(1, 1, 3'd4, 4'd3, 4'd2, 32'h40);
        step("get_src3", 5'd1, 7'h00);
        idle();
        step("get_src3_wait", 5'd1, 7'h00);
        set_d(1, 3'd1, 4'd3, 4'd2);
        step("ackdata_src3", 5'd0, 7'h00);
        idle();
        step("s1_idle", 5'd0, 7'h00);

        // Stalled PutFull held stable, then accepted: legal
        set_a(1, 0, 3'd0, 4'd4, 4'd2, 32'h80);
        step("put_stall_stable", 5'd0, 7'h00);
        set_a(1, 1, 3'd0, 4'd4, 4'd2, 32'h80);
        step("put_accept", 5'd1, 7'h00);
        idle();
        set_d(1, 3'd0, 4'd4, 4'd2);
        step("ack_src4", 5'd0, 7'h00);
        idle();

        // A instability: address changes while stalled
        do_reset("reset_s2");
        set_a(1, 0, 3'd4, 4'd0, 4'd2, 32'h100);
        step("stall_0x100", 5'd0, 7'h00);
        set_a(1, 0, 3'd4, 4'd0, 4'd2, 32'h104);
        step("addr_change", 5'd0, 7'h01);
        idle();
        step("unstable_sticky1", 5'd0, 7'h01);
        step("unstable_sticky2", 5'd0, 7'h01);

        // Opcode mismatch, not-busy response, size mismatch
        do_reset("reset_s3");
        set_a(1, 1, 3'd0, 4'd1, 4'd2, 32'h10);
        step("putfull_src1", 5'd1, 7'h00);
        idle();
        set_d(1, 3'd1, 4'd1, 4'd2);
        step("wrong_opcode", 5'd0, 7'h04);
        set_d(1, 3'd0, 4'd5, 4'd2);
        step("src5_not_busy", 5'd0, 7'h06);
        idle();
        set_a(1, 1, 3'd4, 4'd6, 4'd1, 32'h20);
        step("get_src6_size1", 5'd1, 7'h06);
        idle();
        set_d(1, 3'd1, 4'd6, 4'd2);
        step("size_mismatch", 5'd0, 7'h0E);
        idle();

        // Over MAX outstanding, then A to an already-busy source
        do_reset("reset_s4");
        set_a(1, 1, 3'd4, 4'd0, 4'd2, 32'h0);
        step("get_src0", 5'd1, 7'h00);
        set_a(1, 1, 3'd4, 4'd1, 4'd2, 32'h4);
        step("get_src1", 5'd2, 7'h00);
        set_a(1, 1, 3'd4, 4'd2, 4'd2, 32'h8);
        step("get_src2_over", 5'd3, 7'h20);
        idle();
        step("over_sticky", 5'd3, 7'h20);
        set_a(1, 1, 3'd4, 4'd0, 4'd2, 32'h0);
        step("get_src0_busy", 5'd4, 7'h30);
        idle();

        // Watchdog: flag exactly eight cycles after the A fire
        do_reset("reset_s5");
        set_a(1, 1, 3'd4, 4'd0, 4'd2, 32'h0);
        step("get_src0_wd", 5'd1, 7'h00);
        idle();
        for (int i = 1; i <= 7; i++) begin
            step($sformatf("wd_wait_%0d", i), 5'd1, 7'h00);
        end
        step("wd_timeout", 5'd1, 7'h40);
        step("wd_sticky", 5'd1, 7'h40);

        // Same-cycle response and new request on src 2
        do_reset("reset_s6");
        set_a(1, 1, 3'd0, 4'd2, 4'd2, 32'h30);
        step("putfull_src2", 5'd1, 7'h00);
        set_d(1, 3'd0, 4'd2, 4'd2);
        step("handoff_src2", 5'd1, 7'h00);
        idle();
        set_d(1, 3'd0, 4'd2, 4'd2);
        step("ack_new_src2", 5'd0, 7'h00);
        idle();

        // Reset mid-transaction, with a stalled request across the reset edge
        set_a(1, 1, 3'd4, 4'd3, 4'd2, 32'h50);
        step("get_src3_pending", 5'd1, 7'h00);
        rst = 1'b1;
        set_a(1, 0, 3'd4, 4'd3, 4'd2, 32'h200);
        step("reset_mid", 5'd0, 7'h00);
        rst = 1'b0;
        idle();
        step("no_stab_across_reset", 5'd0, 7'h00);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("no_timeout_after_reset_%0d", i), 5'd0, 7'h00);
        end

        // Illegal A opcode and oversize request
        do_reset("reset_s7");
        set_a(1, 1, 3'd2, 4'd7, 4'd0, 32'h60);
        step("illegal_opcode", 5'd1, 7'h01);
        do_reset("reset_s8");
        set_a(1, 1, 3'd4, 4'd6, 4'd3, 32'h70);
        step("illegal_size", 5'd1, 7'h01);
        do_reset("reset_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlul_master_monitor.md
TLUL_MASTER_MONITOR -- requirements
Module: tlul_master_monitor

Interface
REQ-001 SHALL have parameter AW, default 32, address width in bits.
REQ-002 SHALL have parameter RS, default 4, source-ID width; the source table holds 2^RS entries.
REQ-003 SHALL have parameter MAX, width RS+1, default 2, the maximum legal number of outstanding transactions.
REQ-004 SHALL have parameter TIMEOUT, 16 bits, default 1024, the response watchdog limit in cycles.
REQ-005 SHALL have port master_clock_i, input, 1 bit: the single clock.
REQ-006 SHALL have port master_reset_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have A-channel inputs master_a_{opcode[2:0], param[2:0], size[3:0], source[RS-1:0], address[AW-1:0], mask[3:0], data[31:0], corrupt, valid, ready}.
REQ-008 SHALL have D-channel inputs master_d_{opcode[2:0], param[1:0], size[3:0], source[RS-1:0], denied, data[31:0], corrupt, valid, ready}.
REQ-009 SHALL have outstanding_o, output, RS+1 bits: the live count of outstanding transactions.
REQ-010 SHALL have err_vec_o, output, 7 bits: sticky violation flags (bit map in REQ-021).
REQ-011 SHALL have err_o, output, 1 bit: OR of err_vec_o.

Function
REQ-012 SHALL be passive: all ports except REQ-009..011 are inputs, and the monitor never drives the bus.
REQ-013 SHALL define A fire as a_valid&a_ready and D fire as d_valid&d_ready, sampled at the rising edge.
REQ-014 SHALL keep, per source, an entry {busy, opcode, size}; A fire sets busy and records opcode and size.
REQ-015 SHALL check D fire against the table as it stood before the current edge, then clear that source's busy bit.
REQ-016 SHALL handle A and D fire on the same source in the same cycle as a legal back-to-back exchange: the D check uses the old entry, and the entry then holds the new A.
REQ-017 SHALL update the outstanding count as follows: +1 on A fire only; -1 on D fire only; unchanged when both or neither fire; the count saturates at 0 and at 2^(RS+1)-1.
REQ-018 SHALL require the expected D opcode to be: Get(4) -> AccessAckData(1); PutFullData(0) and PutPartialData(1) -> AccessAck(0).
REQ-019 SHALL check A stability: if a_valid&!a_ready in cycle N, then in cycle N+1 a_valid SHALL remain 1 and opcode, param, size, source, address, mask, data and corrupt SHALL be unchanged; otherwise a violation is flagged.
REQ-020 SHALL run the watchdog counter as follows: it clears on any D fire or when the count is 0; otherwise it increments, saturating at TIMEOUT; reaching TIMEOUT flags a violation.
REQ-021 SHALL map err_vec bits as: [0] A instability; [1] D source not busy; [2] D opcode mismatch; [3] D size mismatch; [4] A fire to an already-busy source (unless same-cycle D fire on that source); [5] count > MAX after update; [6] timeout.
REQ-022 SHALL set each err bit one cycle after the offending edge and hold it until reset.
REQ-023 SHALL flag an illegal A opcode (not 0, 1 or 4) or a_size > 2 as bit [0].

Reset
REQ-024 SHALL, while master_reset_i=1 at an edge, clear all busy bits and set outstanding_o=0, the watchdog to 0, err_vec_o=0 and err_o=0.
REQ-025 SHALL treat reset asserted mid-transaction as follows: all pending entries are discarded, no violation is raised for the lost responses, and no stability check is made across the reset edge.

Structure
REQ-026 SHALL place the opcode constants, the expected-response mapping function and the err_vec bit indices in the shared package tlul_pkg.
REQ-027 SHALL implement the per-source table as the sub-module tlul_monitor_src_table (write port on A fire, read/clear port on D fire, same-cycle ordering per REQ-016).

Verification
REQ-028 SHALL cover: Get src 3 size 2, then AccessAckData src 3 size 2 two cycles later -> outstanding 0->1->0, err_vec=0.
REQ-029 SHALL cover: A valid with a_ready=0, address changes 0x100->0x104 next cycle -> err_vec[0]=1 one cycle later, sticky.
REQ-030 SHALL cover: PutFullData src 1, then AccessAckData src 1 -> err_vec[2]=1; AccessAck src 5 with nothing outstanding -> err_vec[1]=1.
REQ-031 SHALL cover: three Gets on srcs 0, 1, 2 with no responses, MAX=2 -> outstanding=3, err_vec[5]=1.
REQ-032 SHALL cover: Get src 0 with no response, TIMEOUT=8 -> err_vec[6]=1 eight cycles after the A fire.
REQ-033 SHALL cover: same-cycle AccessAck src 2 and PutFull src 2 -> count unchanged, err_vec=0; reset mid-transaction -> all outputs 0 on the next cycle.
